// File: rtl/fcs32_pkg.sv
// fcs32_pkg: shared types, constants and CRC helpers for the FCS generator.
// fcs32_32 folds one 32-bit word into the CRC (poly 0x04C11DB7, MSB first).
// fcs32_brev bit-reverses a 32-bit word for transmission order.
package fcs32_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FRAME  = 2'd1,
        APPEND = 2'd2
    } fcs_state_e;

    localparam logic [31:0] ONES       = 32'hFFFF_FFFF;
    localparam logic [31:0] ZEROS      = 32'h0000_0000;
    localparam logic [31:0] FCS32_POLY = 32'h04C1_1DB7;

    function automatic logic [31:0] fcs32_32(input logic [31:0] d, input logic [31:0] c);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 31; i >= 0; i--) begin
            fb = r[31] ^ d[i];
            r  = {r[30:0], 1'b0} ^ (fb ? FCS32_POLY : ZEROS);
        end
        return r;
    endfunction

    function automatic logic [31:0] fcs32_brev(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

endpackage

// File: rtl/fcs32_ostage.sv
// fcs32_ostage: output register slice. Loads a new beat whenever the slot
// is empty or being drained this cycle, otherwise holds all fields stable.
module fcs32_ostage (
    input  logic        pclk_i,
    input  logic        rst_n_i,
    input  logic [31:0] d_data_i,
    input  logic        d_sof_i,
    input  logic        d_eof_i,
    input  logic        d_val_i,
    input  logic        out_rdy_i,
    output logic [31:0] out_data_o,
    output logic        out_sof_o,
    output logic        out_eof_o,
    output logic        out_val_o,
    output logic        ld_o
);

    logic [31:0] data_q;
    logic        sof_q, eof_q, val_q;

    assign ld_o       = !val_q | out_rdy_i;
    assign out_data_o = data_q;
    assign out_sof_o  = sof_q;
    assign out_eof_o  = eof_q;
    assign out_val_o  = val_q;

    // Output slot: load on ld, hold under backpressure.
    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q <= '0;
            sof_q  <= 1'b0;
            eof_q  <= 1'b0;
            val_q  <= 1'b0;
        end else if (ld_o) begin
            data_q <= d_data_i;
            sof_q  <= d_sof_i;
            eof_q  <= d_eof_i;
            val_q  <= d_val_i;
        end
    end

endmodule

// File: rtl/fcs32_gen_ctl.sv
// fcs32_gen_ctl: frame sequencer that forwards SOF/EOF-delimited word frames
// and appends a bit-reversed CRC-32 word as the new last beat of each frame.
// Optional: define FCS32_GEN_CNT_EN to add frm_cnt_o (FCS words sent, wraps).
module fcs32_gen_ctl
    import fcs32_pkg::*;
(
    input  logic        pclk_i,
    input  logic        rst_n_i,
    input  logic [31:0] in_data_i,
    input  logic        in_sof_i,
    input  logic        in_eof_i,
    input  logic        in_val_i,
    output logic        in_rdy_o,
    output logic [31:0] out_data_o,
    output logic        out_sof_o,
    output logic        out_eof_o,
    output logic        out_val_o,
    input  logic        out_rdy_i,
`ifdef FCS32_GEN_CNT_EN
    output logic [15:0] frm_cnt_o,
`endif
    output logic        err_o
);

    fcs_state_e  state_q;
    logic [31:0] crc_q;
    logic        err_q;
    logic        ld, acc;
    logic [31:0] nxt_data;
    logic        nxt_sof, nxt_eof, nxt_val;

    assign in_rdy_o = ld & (state_q != APPEND);
    assign acc      = in_val_i & in_rdy_o;
    assign err_o    = err_q;

    // Next beat for the output slot: a forwarded data word or the FCS word.
    always_comb begin
        nxt_data = in_data_i;
        nxt_sof  = in_sof_i;
        nxt_eof  = 1'b0;
        nxt_val  = 1'b0;
        case (state_q)
            IDLE:    nxt_val = acc & in_sof_i;
            FRAME:   nxt_val = acc;
            APPEND: begin
                nxt_data = fcs32_brev(crc_q);
                nxt_sof  = 1'b0;
                nxt_eof  = 1'b1;
                nxt_val  = 1'b1;
            end
            default: nxt_val = 1'b0;
        endcase
    end

    fcs32_ostage u_ostage (
        .pclk_i     (pclk_i),
        .rst_n_i    (rst_n_i),
        .d_data_i   (nxt_data),
        .d_sof_i    (nxt_sof),
        .d_eof_i    (nxt_eof),
        .d_val_i    (nxt_val),
        .out_rdy_i  (out_rdy_i),
        .out_data_o (out_data_o),
        .out_sof_o  (out_sof_o),
        .out_eof_o  (out_eof_o),
        .out_val_o  (out_val_o),
        .ld_o       (ld)
    );

    // Frame FSM with running CRC; any accepted SOF restarts the CRC from ONES.
    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            crc_q   <= ONES;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: if (acc) begin
                    if (in_sof_i) begin
                        crc_q   <= fcs32_32(in_data_i, ONES);
                        state_q <= in_eof_i ? APPEND : FRAME;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                FRAME: if (acc) begin
                    crc_q   <= fcs32_32(in_data_i, in_sof_i ? ONES : crc_q);
                    err_q   <= in_sof_i;
                    state_q <= in_eof_i ? APPEND : FRAME;
                end
                APPEND: if (ld) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FCS32_GEN_CNT_EN
    logic [15:0] frm_cnt_q;
    assign frm_cnt_o = frm_cnt_q;

    // Count FCS words handed downstream; wraps naturally at 16 bits.
    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i)                               frm_cnt_q <= '0;
        else if (out_val_o & out_rdy_i & out_eof_o) frm_cnt_q <= frm_cnt_q + 16'd1;
    end
`endif

endmodule
